// File: rtl/csa42_pkg.sv
// Shared helpers for the pipelined 4:2 carry-save reduction tree:
// level-count arithmetic and the list of supported operand counts.
package csa42_pkg;

    // Operand counts the tree supports; each must be a power of two >= 4.
    localparam int N_LEGAL = 4;
    localparam int LEGAL_N_OPS [N_LEGAL] = '{4, 8, 16, 32};

    // Ceiling log2 for elaboration-time sizing.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int p = 1; p < value; p = p * 2) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Each 4:2 level halves the vector count, and the last level leaves two
    // vectors, so N operands need log2(N) - 1 levels.
    function automatic int n_levels(input int n_ops);
        return clog2(n_ops) - 1;
    endfunction

    // True when n_ops appears in the supported list.
    function automatic bit is_legal_n_ops(input int n_ops);
        bit found;
        found = 1'b0;
        for (int i = 0; i < N_LEGAL; i++) begin
            if (LEGAL_N_OPS[i] == n_ops) begin
                found = 1'b1;
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/csa42_row.sv
// One combinational row of 4:2 compressors across WIDTH bits. The lateral
// carry (cout) of bit i feeds bit i+1 but never ripples further, so the row
// depth is constant in WIDTH. Results are modulo 2^WIDTH: the MSB cout and
// the MSB cy fall off the top and are never computed.
module csa42_row #(
    parameter int WIDTH = 128
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] s_o,
    output logic [WIDTH-1:0] c_o
);

    logic [WIDTH-1:0] ab;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] cin;
    logic [WIDTH-2:0] cout_lo;
    logic [WIDTH-2:0] cy_lo;

    // Per-bit compressor equations; cout is the majority of a, b and c.
    always_comb begin
        ab      = a_i ^ b_i;
        x       = ab ^ c_i ^ d_i;
        cout_lo = (ab[WIDTH-2:0] & c_i[WIDTH-2:0]) | (~ab[WIDTH-2:0] & a_i[WIDTH-2:0]);
        cin     = {cout_lo, 1'b0};
        cy_lo   = (x[WIDTH-2:0] & cin[WIDTH-2:0]) | (~x[WIDTH-2:0] & d_i[WIDTH-2:0]);
        s_o     = x ^ cin;
        c_o     = {cy_lo, 1'b0};
    end

endmodule

// File: rtl/csa42_tree_pipe.sv
// Pipelined 4:2 carry-save tree: N_OPS operands reduce to a sum/carry pair,
// with a register stage after every compressor level. A single global
// advance signal moves every stage at once, so a stalled output freezes the
// whole pipe and in_ready mirrors it combinationally.
module csa42_tree_pipe
    import csa42_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int N_OPS = 16,
    parameter int TAG_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_OPS*WIDTH-1:0] ops_i,
    input  logic [TAG_W-1:0]       tag_i,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       sum_o,
    output logic [WIDTH-1:0]       carry_o,
    output logic [TAG_W-1:0]       tag_o
);

    localparam int L    = n_levels(N_OPS);
    localparam int HALF = N_OPS / 2;

    if (!is_legal_n_ops(N_OPS)) begin : g_bad_n_ops
        $error("csa42_tree_pipe: N_OPS must be one of 4, 8, 16, 32");
    end

    logic                 adv;
    logic [L-1:0]         valid_q;
    logic [L-1:0]         valid_d;
    logic [TAG_W-1:0]     tag_q  [L];
    logic [TAG_W-1:0]     tag_d  [L];
    // Level l consumes lvl_in[l][0 .. N_OPS>>l - 1]; unused slots are tied off.
    logic [WIDTH-1:0]     lvl_in [L][N_OPS];
    // Level l produces vec_d[l][0 .. N_OPS>>(l+1) - 1]; S at even, C at odd.
    logic [WIDTH-1:0]     vec_d  [L][HALF];
    logic [WIDTH-1:0]     vec_q  [L][HALF];

    assign adv       = ~valid_q[L-1] | out_ready;
    assign in_ready  = adv;
    assign out_valid = valid_q[L-1];
    assign sum_o     = vec_q[L-1][0];
    assign carry_o   = vec_q[L-1][1];
    assign tag_o     = tag_q[L-1];

    for (genvar gi = 0; gi < L; gi++) begin : g_lvl
        localparam int N_IN   = N_OPS >> gi;
        localparam int N_ROWS = N_IN / 4;

        // Level inputs: raw operands for level 0, the previous stage otherwise.
        for (genvar gj = 0; gj < N_OPS; gj++) begin : g_in
            if (gi == 0) begin : g_src_ops
                assign lvl_in[gi][gj] = ops_i[gj*WIDTH +: WIDTH];
            end else if (gj < N_IN) begin : g_src_stage
                assign lvl_in[gi][gj] = vec_q[gi-1][gj];
            end else begin : g_src_none
                assign lvl_in[gi][gj] = '0;
            end
        end

        // Group r takes vectors 4r..4r+3 and yields vectors 2r (S), 2r+1 (C).
        for (genvar gr = 0; gr < N_ROWS; gr++) begin : g_row
            csa42_row #(
                .WIDTH (WIDTH)
            ) u_row (
                .a_i (lvl_in[gi][4*gr]),
                .b_i (lvl_in[gi][4*gr+1]),
                .c_i (lvl_in[gi][4*gr+2]),
                .d_i (lvl_in[gi][4*gr+3]),
                .s_o (vec_d[gi][2*gr]),
                .c_o (vec_d[gi][2*gr+1])
            );
        end

        for (genvar gk = 2 * N_ROWS; gk < HALF; gk++) begin : g_pad
            assign vec_d[gi][gk] = '0;
        end
    end

    // Next-state for the valid/tag shift chain; stage 0 takes the input port.
    always_comb begin
        valid_d    = '0;
        valid_d[0] = in_valid;
        tag_d[0]   = tag_i;
        for (int l = 1; l < L; l++) begin
            valid_d[l] = valid_q[l-1];
            tag_d[l]   = tag_q[l-1];
        end
    end

    // Stage registers: cleared on reset, all advance together on adv, else hold.
    // Data loads even on bubbles; it is ignored while the valid bit is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int l = 0; l < L; l++) begin
                tag_q[l] <= '0;
                for (int k = 0; k < HALF; k++) begin
                    vec_q[l][k] <= '0;
                end
            end
        end else if (adv) begin
            valid_q <= valid_d;
            for (int l = 0; l < L; l++) begin
                tag_q[l] <= tag_d[l];
                for (int k = 0; k < HALF; k++) begin
                    vec_q[l][k] <= vec_d[l][k];
                end
            end
        end
    end

endmodule

// File: doc/csa42_tree_pipe.md
# csa42_tree_pipe

Parametrised, pipelined 4:2 carry-save reduction tree. It reduces N_OPS unsigned WIDTH-bit partial products to one sum/carry pair, with a register stage after every compressor level and a valid/ready handshake that stalls the whole pipe. It sits between partial-product generation and the final carry-propagate adder of the mantissa multiplier. It replaces a single unregistered 4:2 compressor row.

## Interface
- WIDTH, 128: bit width of every operand and both outputs; all arithmetic is mod 2^WIDTH.
- N_OPS, 16: operand count; legal values 4, 8, 16, 32 (elaboration error otherwise).
- TAG_W, 8: width of the sideband tag carried alongside each operand set.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  operand set on ops_i/tag_i is valid.
- in_ready  output  1  pipe can accept an operand set this cycle.
- ops_i  input  N_OPS*WIDTH  packed operands; operand k is ops_i[k*WIDTH +: WIDTH].
- tag_i  input  TAG_W  sideband tag, delivered unchanged with the result.
- out_valid  output  1  sum_o/carry_o/tag_o hold a valid result.
- out_ready  input  1  downstream accepts the result this cycle.
- sum_o  output  WIDTH  reduced sum vector.
- carry_o  output  WIDTH  reduced carry vector, already shifted to weight; sum_o + carry_o ≡ Σ operands mod 2^WIDTH.
- tag_o  output  TAG_W  tag of the result on sum_o/carry_o.

## Operation
- Levels: L = log2(N_OPS) − 1. With N_OPS = 16, L = 3. Each level turns groups of 4 vectors into 2, so vector count halves per level.
- Row function, bit i, with inputs a,b,c,d and cin = cout of bit i−1 (cin of bit 0 = 0):
  - x = a^b^c^d
  - s = x^cin
  - cy = (x&cin)|(~x&d)
  - cout = ((a^b)&c)|(~(a^b)&a)
- Row outputs:
  - S = s
  - C = {cy[WIDTH−2:0], 1'b0}
  - cout of the MSB and cy[WIDTH−1] are discarded (mod 2^WIDTH).
- Grouping at each level: group j takes vectors 4j..4j+3 as (a,b,c,d) and produces S then C, which become vectors 2j and 2j+1 of the next level.
- Final level output is registered: S → sum_o, C → carry_o.
- Each stage register holds a valid bit, the data vectors and the tag.
- Global advance: adv = ~out_valid | out_ready.
  - When adv = 1, every stage loads the stage before it. Stage 0 loads in_valid & in_ready together with ops_i/tag_i.
  - When adv = 0, all stages hold.
  - in_ready = adv (combinational).
- Bubbles propagate as valid = 0. Data registers may load on bubbles; their contents are don't-care while valid = 0.

## Timing
- Latency L cycles when unstalled: a set accepted at edge t appears with out_valid = 1 after edge t+L−1 (N_OPS = 4 → 1 cycle).
- Throughput: one set per cycle while out_ready = 1.
- Stall: out_valid = 1 with out_ready = 0 freezes the pipe and holds outputs stable. in_ready drops combinationally in the same cycle, and no set is lost or duplicated.
- Simultaneous out_ready = 1 and in_valid = 1 on a full pipe: result retires and the new set enters on the same edge.
- Reset (rst_n = 0 at an edge), including mid-operation:
  - all valid bits clear, so out_valid = 0;
  - sum_o, carry_o, tag_o = 0;
  - in-flight sets are dropped;
  - in_ready = 1 from the first cycle after reset, because out_valid = 0.
- No combinational path from ops_i to any output. The only combinational input-to-output path is out_ready → in_ready.

## Structure
- Package csa42_pkg:
  - function clog2;
  - function n_levels(N_OPS);
  - localparam list of legal N_OPS values.
- Sub-module csa42_row #(WIDTH):
  - purely combinational;
  - one 4:2 row with internal cout chain;
  - outputs S and pre-shifted C.
- Top level instantiates N_OPS/2^(l+2) rows at level l via generate, plus the per-level valid/tag/data registers.

## Test plan
- N_OPS = 4, WIDTH = 8: ops = 0x01, 0x02, 0x03, 0x04, out_ready = 1 → after 1 cycle out_valid = 1 and (sum_o + carry_o) & 0xFF = 0x0A.
- N_OPS = 16, WIDTH = 128: all operands = 2^128−1 → after 3 cycles (sum_o + carry_o) mod 2^128 = 2^128−16; tag 0x5A appears on tag_o.
- Back-to-back: 100 random sets with in_valid = 1 and out_ready = 1 → 100 results in order with matching tags, one per cycle after 3-cycle fill.
- Backpressure: out_ready held 0 for 5 cycles with a full pipe → in_ready = 0 and outputs stable. Releasing it retires every set exactly once in order.
- Reset mid-stream: rst_n = 0 for one edge while 3 sets are in flight → next cycle out_valid = 0, sum_o = carry_o = 0, in_ready = 1, and no stale set emerges afterwards.
- Carry discard at MSB: WIDTH = 8, ops = 0x80 ×4 → (sum_o + carry_o) & 0xFF = 0x00.
